// File: rtl/pipe_ctrl_stage_pkg.sv
// Shared opcode/ALU constants and the registered control-bundle layout
// for the pipelined instruction control stage.
package pipe_ctrl_stage_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_MUL  = 5'h02;
    localparam logic [4:0] OP_DIV  = 5'h03;
    localparam logic [4:0] OP_MOD  = 5'h04;
    localparam logic [4:0] OP_CMP  = 5'h05;
    localparam logic [4:0] OP_NOT  = 5'h08;
    localparam logic [4:0] OP_MOV  = 5'h09;
    localparam logic [4:0] OP_NOP  = 5'h0D;
    localparam logic [4:0] OP_LD   = 5'h0E;
    localparam logic [4:0] OP_ST   = 5'h0F;
    localparam logic [4:0] OP_BEQ  = 5'h10;
    localparam logic [4:0] OP_BGT  = 5'h11;
    localparam logic [4:0] OP_B    = 5'h12;
    localparam logic [4:0] OP_CALL = 5'h13;
    localparam logic [4:0] OP_RET  = 5'h14;

    localparam logic [4:0] ALU_ADD = 5'h00;
    localparam logic [4:0] ALU_MUL = 5'h02;
    localparam logic [4:0] ALU_DIV = 5'h03;
    localparam logic [4:0] ALU_MOD = 5'h04;
    localparam logic [4:0] ALU_NOP = 5'h0D;

    typedef struct packed {
        logic       isSt;
        logic       isLd;
        logic       isBeq;
        logic       isBgt;
        logic       isRet;
        logic       isImm;
        logic       isWb;
        logic       isUbranch;
        logic       isCall;
        logic [4:0] aluSig;
        logic       illegal;
    } ctrl_t;

    // Which instruction fields name a register this instruction reads.
    typedef struct packed {
        logic rs1;
        logic rs2;
        logic rd;
        logic ra;
    } src_t;

    function automatic logic isMultiCycle(input logic [4:0] aluSig);
        return aluSig inside {ALU_MUL, ALU_DIV, ALU_MOD};
    endfunction

endpackage

// File: rtl/pipe_ctrl_stage_ctrl_decode.sv
// Combinational opcode decode: control bundle, destination register and
// the set of registers the instruction reads (for load-use detection).
module ctrl_decode
    import pipe_ctrl_stage_pkg::*;
#(
    parameter int OPW    = 5,
    parameter int REGW   = 4,
    parameter int RA_IDX = 15
) (
    input  logic [OPW-1:0]  opcode,
    input  logic            imm,
    input  logic [REGW-1:0] rd,
    output ctrl_t           ctrl,
    output logic [REGW-1:0] dstRd,
    output src_t            src
);

    logic [4:0] op5;
    assign op5 = 5'(opcode);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        ctrl        = '0;
        ctrl.aluSig = ALU_NOP;
        dstRd       = rd;
        src         = '0;
        src.rs2     = !imm;
        if (32'(opcode) > 32'(OP_RET)) begin
            ctrl.illegal = 1'b1;
        end else begin
            ctrl.isImm = imm;
            src.rs1    = 1'b1;
            case (op5)
                OP_LD: begin
                    ctrl.aluSig = ALU_ADD;
                    ctrl.isLd   = 1'b1;
                    ctrl.isWb   = 1'b1;
                end
                OP_ST: begin
                    ctrl.aluSig = ALU_ADD;
                    ctrl.isSt   = 1'b1;
                    src.rd      = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.isBeq = 1'b1;
                    src.rs1    = 1'b0;
                end
                OP_BGT: begin
                    ctrl.isBgt = 1'b1;
                    src.rs1    = 1'b0;
                end
                OP_B: begin
                    ctrl.isUbranch = 1'b1;
                    src.rs1        = 1'b0;
                end
                OP_CALL: begin
                    ctrl.isUbranch = 1'b1;
                    ctrl.isCall    = 1'b1;
                    ctrl.isWb      = 1'b1;
                    dstRd          = REGW'(RA_IDX);
                    src.rs1        = 1'b0;
                end
                OP_RET: begin
                    ctrl.isUbranch = 1'b1;
                    ctrl.isRet     = 1'b1;
                    src.ra         = 1'b1;
                end
                default: begin
                    // Plain ALU ops: the ALU code is the opcode itself.
                    ctrl.aluSig = op5;
                    ctrl.isWb   = !(op5 inside {OP_CMP, OP_NOP});
                    src.rs1     = !(op5 inside {OP_MOV, OP_NOT, OP_NOP});
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Registered control stage between IF/ID and ID/EX: valid/ready handshake,
// output bundle register, load-use and multi-cycle interlocks, flush.
module pipe_ctrl_stage
    import pipe_ctrl_stage_pkg::*;
#(
    parameter int OPW        = 5,
    parameter int REGW       = 4,
    parameter int RA_IDX     = 15,
    parameter int MULDIV_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_opcode,
    input  logic            in_i,
    input  logic [REGW-1:0] in_rd,
    input  logic [REGW-1:0] in_rs1,
    input  logic [REGW-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_is_st,
    output logic            out_is_ld,
    output logic            out_is_beq,
    output logic            out_is_bgt,
    output logic            out_is_ret,
    output logic            out_is_imm,
    output logic            out_is_wb,
    output logic            out_is_ubranch,
    output logic            out_is_call,
    output logic [4:0]      out_alu_sig,
    output logic [REGW-1:0] out_rd,
    output logic            out_illegal
);

    localparam int CNTW = $clog2(MULDIV_LAT) + 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MULDIV_LAT - 1);

    ctrl_t           decCtrl;
    logic [REGW-1:0] decRd;
    src_t            decSrc;

    ctrl_decode #(.OPW(OPW), .REGW(REGW), .RA_IDX(RA_IDX)) uDecode (
        .opcode (in_opcode),
        .imm    (in_i),
        .rd     (in_rd),
        .ctrl   (decCtrl),
        .dstRd  (decRd),
        .src    (decSrc)
    );

    logic            outValid;
    ctrl_t           outCtrl;
    logic [REGW-1:0] outRd;
    logic            ldPend;
    logic [REGW-1:0] ldRd;
    logic [CNTW-1:0] mdivCnt;

    logic ldStall;
    logic inXfer;
    logic outXfer;

    assign ldStall = ldPend && ((decSrc.rs1 && in_rs1 == ldRd) ||
                                (decSrc.rs2 && in_rs2 == ldRd) ||
                                (decSrc.rd  && in_rd  == ldRd) ||
                                (decSrc.ra  && REGW'(RA_IDX) == ldRd));

    assign in_ready = !flush && (!outValid || out_ready) && !ldStall && (mdivCnt == '0);
    assign inXfer   = in_valid && in_ready;
    assign outXfer  = outValid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid <= 1'b0;
            outCtrl  <= '0;
            outRd    <= '0;
            ldPend   <= 1'b0;
            ldRd     <= '0;
            mdivCnt  <= '0;
        end else if (flush) begin
            // Flush wins over any transfer; the bundle fields may keep stale data.
            outValid <= 1'b0;
            ldPend   <= 1'b0;
            mdivCnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (inXfer) begin
                outValid <= 1'b1;
                outCtrl  <= decCtrl;
                outRd    <= decRd;
            end else if (outXfer) begin
                outValid <= 1'b0;
            end
            ldPend <= outXfer && outCtrl.isLd;
            if (outXfer && outCtrl.isLd) begin
                ldRd <= outRd;
            end
            if (outXfer && isMultiCycle(outCtrl.aluSig)) begin
                mdivCnt <= CNT_INIT;
            end else if (mdivCnt != '0) begin
                mdivCnt <= mdivCnt - 1'b1;
            end
        end
    end

    assign out_valid      = outValid;
    assign out_is_st      = outCtrl.isSt;
    assign out_is_ld      = outCtrl.isLd;
    assign out_is_beq     = outCtrl.isBeq;
    assign out_is_bgt     = outCtrl.isBgt;
    assign out_is_ret     = outCtrl.isRet;
    assign out_is_imm     = outCtrl.isImm;
    assign out_is_wb      = outCtrl.isWb;
    assign out_is_ubranch = outCtrl.isUbranch;
    assign out_is_call    = outCtrl.isCall;
    assign out_alu_sig    = outCtrl.aluSig;
    assign out_rd         = outRd;
    assign out_illegal    = outCtrl.illegal;

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Randomized and directed bench for pipe_ctrl_stage; two instances
// (MULDIV_LAT = 4 and 1) are each compared against an abstract model.
module tb_pipe_ctrl_stage;

    localparam int RA = 15;

    typedef struct packed {
        logic       st, ld, beq, bgt, ret, imm, wb, ub, call;
        logic [4:0] alu;
        logic [3:0] rd;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, flush, in_valid, in_i, out_ready;
    logic [4:0] in_opcode;
    logic [3:0] in_rd, in_rs1, in_rs2;

    logic       inRdy[2], oValid[2], oSt[2], oLd[2], oBeq[2], oBgt[2], oRet[2];
    logic       oImm[2], oWb[2], oUb[2], oCall[2], oIll[2];
    logic [4:0] oAlu[2];
    logic [3:0] oRd[2];

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    pipe_ctrl_stage #(.OPW(5), .REGW(4), .RA_IDX(RA), .MULDIV_LAT(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(inRdy[0]),
        .in_opcode(in_opcode), .in_i(in_i), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(oValid[0]), .out_ready(out_ready), .out_is_st(oSt[0]), .out_is_ld(oLd[0]),
        .out_is_beq(oBeq[0]), .out_is_bgt(oBgt[0]), .out_is_ret(oRet[0]), .out_is_imm(oImm[0]),
        .out_is_wb(oWb[0]), .out_is_ubranch(oUb[0]), .out_is_call(oCall[0]),
        .out_alu_sig(oAlu[0]), .out_rd(oRd[0]), .out_illegal(oIll[0])
    );

    pipe_ctrl_stage #(.OPW(5), .REGW(4), .RA_IDX(RA), .MULDIV_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(inRdy[1]),
        .in_opcode(in_opcode), .in_i(in_i), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(oValid[1]), .out_ready(out_ready), .out_is_st(oSt[1]), .out_is_ld(oLd[1]),
        .out_is_beq(oBeq[1]), .out_is_bgt(oBgt[1]), .out_is_ret(oRet[1]), .out_is_imm(oImm[1]),
        .out_is_wb(oWb[1]), .out_is_ubranch(oUb[1]), .out_is_call(oCall[1]),
        .out_alu_sig(oAlu[1]), .out_rd(oRd[1]), .out_illegal(oIll[1])
    );

    // Model state: stalls are tracked as edge numbers rather than counters.
    int   lat[2] = '{4, 1};
    int   edgeNo;
    bit   mValid[2];
    exp_t mBun[2];
    int   ldEdge[2];
    logic [3:0] mLdRd[2];
    int   mdivFree[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t refDecode(input logic [4:0] op, input bit i, input logic [3:0] rd);
        exp_t e = '0;
        e.alu = 5'h0D;
        e.rd  = rd;
        if (op > 5'd20) begin
            e.ill = 1'b1;
            return e;
        end
        e.imm = i;
        if (op <= 5'd13) begin
            e.alu = op;
            e.wb  = !(op == 5'd5 || op == 5'd13);
        end else begin
            case (op)
                5'd14:   begin e.alu = 5'd0; e.ld = 1'b1; e.wb = 1'b1; end
                5'd15:   begin e.alu = 5'd0; e.st = 1'b1; end
                5'd16:   e.beq = 1'b1;
                5'd17:   e.bgt = 1'b1;
                5'd18:   e.ub = 1'b1;
                5'd19:   begin e.ub = 1'b1; e.call = 1'b1; e.wb = 1'b1; e.rd = 4'(RA); end
                default: begin e.ub = 1'b1; e.ret = 1'b1; end
            endcase
        end
        return e;
    endfunction

    function automatic bit refReads(input logic [4:0] op, input bit i, input logic [3:0] rd,
                                    input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] r);
        bit usesRs1;
        usesRs1 = (op <= 5'd20) && !(op inside {5'd8, 5'd9, 5'd13, 5'd16, 5'd17, 5'd18, 5'd19});
        return (usesRs1 && rs1 == r) || (!i && rs2 == r) ||
               (op == 5'd15 && rd == r) || (op == 5'd20 && r == 4'(RA));
    endfunction

    function automatic bit refReady(input int k);
        bit ldBlock;
        ldBlock = (ldEdge[k] == edgeNo) &&
                  refReads(in_opcode, in_i, in_rd, in_rs1, in_rs2, mLdRd[k]);
        return !flush && (!mValid[k] || out_ready) && !ldBlock && !(edgeNo < mdivFree[k]);
    endfunction

    function automatic exp_t dutBun(input int k);
        exp_t e;
        e = {oSt[k], oLd[k], oBeq[k], oBgt[k], oRet[k], oImm[k], oWb[k], oUb[k], oCall[k],
             oAlu[k], oRd[k], oIll[k]};
        return e;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mValid[k]   = 1'b0;
            mBun[k]     = '0;
            ldEdge[k]   = -1;
            mLdRd[k]    = '0;
            mdivFree[k] = 0;
        end
    endtask

    task automatic checkOutputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(oValid[k]), 32'(mValid[k]));
            check($sformatf("bundle[%0d]", k), 32'(dutBun(k)), 32'(mBun[k]));
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model and DUT, check outputs.
    // acc reports whether the LAT=4 instance accepted the instruction.
    task automatic step(input bit v, input logic [4:0] op, input bit i, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input bit ordy,
                        input bit fl, output bit acc);
        bit   rdyE[2];
        exp_t old;
        bit   oxfer;
        in_valid = v; in_opcode = op; in_i = i; in_rd = rd;
        in_rs1 = rs1; in_rs2 = rs2; out_ready = ordy; flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            rdyE[k] = refReady(k);
            check($sformatf("in_ready[%0d]", k), 32'(inRdy[k]), 32'(rdyE[k]));
        end
        acc = v && rdyE[0];
        @(posedge clk);
        edgeNo++;
        for (int k = 0; k < 2; k++) begin
            old   = mBun[k];
            oxfer = mValid[k] && ordy;
            if (fl) begin
                mValid[k]   = 1'b0;
                ldEdge[k]   = -1;
                mdivFree[k] = 0;
            end else begin
                if (v && rdyE[k]) begin
                    mBun[k]   = refDecode(op, i, rd);
                    mValid[k] = 1'b1;
                end else if (oxfer) begin
                    mValid[k] = 1'b0;
                end
                if (oxfer && old.ld) begin
                    ldEdge[k] = edgeNo;
                    mLdRd[k]  = old.rd;
                end
                if (oxfer && old.alu inside {5'd2, 5'd3, 5'd4})
                    mdivFree[k] = edgeNo + lat[k] - 1;
            end
        end
        #1;
        checkOutputs();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int c = 0; c < n; c++) step(1'b0, 5'd13, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
    endtask

    // Present an instruction (out_ready = 1) until the LAT=4 instance accepts it.
    task automatic issue(input logic [4:0] op, input bit i, input logic [3:0] rd,
                         input logic [3:0] rs1, input logic [3:0] rs2);
        bit acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) step(1'b1, op, i, rd, rs1, rs2, 1'b1, 1'b0, acc);
        if (!acc) check("issue_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset between clock edges; outputs must clear without a clock.
    task automatic midReset();
        #2;
        flush = 1'b0;
        reset = 1'b1;
        #1;
        modelReset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valid[%0d]", k), 32'(oValid[k]), 32'd0);
            check($sformatf("rst_bundle[%0d]", k), 32'(dutBun(k)), 32'd0);
            check($sformatf("rst_in_ready[%0d]", k), 32'(inRdy[k]), 32'd1);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit acc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_i = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        edgeNo = 0;
        modelReset();
        #11;
        checkOutputs();
        reset = 1'b0;

        // First instruction after reset: add with rs1 = 1
        issue(5'h00, 1'b0, 4'd2, 4'd1, 4'd0);

        // Opcode sweep, both immediate settings, including illegal opcodes
        for (int op = 0; op < 32; op++)
            for (int i = 0; i < 2; i++)
                issue(5'(op), 1'(i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
        idle(4);

        // Load-use: dependent and independent followers
        issue(5'h0E, 1'b1, 4'd3, 4'd1, 4'd0);
        issue(5'h00, 1'b0, 4'd4, 4'd3, 4'd5);
        issue(5'h00, 1'b0, 4'd7, 4'd4, 4'd3);
        idle(3);
        issue(5'h0E, 1'b1, 4'd3, 4'd1, 4'd0);
        issue(5'h00, 1'b0, 4'd4, 4'd6, 4'd5);
        issue(5'h00, 1'b0, 4'd7, 4'd3, 4'd3);
        idle(3);

        // Multi-cycle: mul followed by adds
        issue(5'h02, 1'b0, 4'd1, 4'd2, 4'd3);
        issue(5'h00, 1'b0, 4'd4, 4'd6, 4'd5);
        issue(5'h00, 1'b0, 4'd4, 4'd6, 4'd5);
        idle(5);

        // Backpressure: bundle held for 5 cycles, then released
        issue(5'h01, 1'b0, 4'd8, 4'd9, 4'd10);
        for (int c = 0; c < 5; c++) step(1'b1, 5'h06, 1'b1, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0, acc);
        step(1'b1, 5'h06, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1, 1'b0, acc);
        idle(2);

        // Flush with pending load-use and multi-cycle interlocks
        issue(5'h0E, 1'b1, 4'd3, 4'd1, 4'd0);
        step(1'b0, 5'h0D, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        step(1'b1, 5'h00, 1'b0, 4'd4, 4'd3, 4'd3, 1'b1, 1'b1, acc);
        step(1'b1, 5'h00, 1'b0, 4'd4, 4'd3, 4'd3, 1'b1, 1'b0, acc);
        issue(5'h03, 1'b1, 4'd1, 4'd2, 4'd3);
        step(1'b0, 5'h0D, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        step(1'b1, 5'h07, 1'b0, 4'd4, 4'd3, 4'd3, 1'b1, 1'b1, acc);
        step(1'b1, 5'h07, 1'b0, 4'd4, 4'd3, 4'd3, 1'b1, 1'b0, acc);
        idle(2);

        // Reset in the middle of a multi-cycle stall
        issue(5'h04, 1'b1, 4'd1, 4'd2, 4'd3);
        step(1'b0, 5'h0D, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, acc);
        midReset();
        issue(5'h00, 1'b0, 4'd2, 4'd1, 4'd0);

        // Randomized traffic with hazard-prone register choices
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] r[3];
            for (int j = 0; j < 3; j++)
                r[j] = ($urandom_range(0, 7) == 0) ? 4'(RA) : 4'($urandom_range(0, 3));
            step($urandom_range(0, 4) != 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 r[0], r[1], r[2], $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
            if ($urandom_range(0, 499) == 0) midReset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_ctrl_stage.md
# pipe_ctrl_stage

Registered, pipelined successor of the combinational instruction control decoder. It sits between the IF/ID and ID/EX pipeline registers and accepts one instruction per valid/ready handshake. It decodes opcode fields into the control bundle and holds that bundle in an output register. It also inserts interlock bubbles for load-use and multi-cycle ALU hazards, and discards in-flight state on a branch flush.

## Interface
- OPW, 5, opcode width
- REGW, 4, register index width
- RA_IDX, 15, return-address register index written by call and read by ret
- MULDIV_LAT, 4, EX occupancy in cycles of mul/div/mod (1 = no stall)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- flush  in  1  branch taken in EX; kill this stage
- in_valid  in  1  instruction fields valid
- in_ready  out  1  stage accepts instruction this cycle
- in_opcode  in  OPW  opcode
- in_i  in  1  immediate bit
- in_rd, in_rs1, in_rs2  in  REGW each  register fields
- out_valid  out  1  control bundle valid
- out_ready  in  1  EX accepts bundle
- out_is_st, out_is_ld, out_is_beq, out_is_bgt, out_is_ret, out_is_imm, out_is_wb, out_is_ubranch, out_is_call  out  1 each  control flags
- out_alu_sig  out  5  ALU operation code
- out_rd  out  REGW  destination (RA_IDX for call)
- out_illegal  out  1  opcode outside 0x00–0x14; bundle is a nop

## Operation
- Decode map:
  - 0x00–0x0D: out_alu_sig = opcode; out_is_wb = 1, except cmp (0x05) and nop (0x0D), which have out_is_wb = 0.
  - ld (0x0E): alu = add, ld = 1, wb = 1.
  - st (0x0F): alu = add, st = 1.
  - beq (0x10) / bgt (0x11): alu = 0x0D, beq or bgt = 1.
  - b (0x12): alu = 0x0D, ubranch = 1.
  - call (0x13): alu = 0x0D, ubranch = 1, call = 1, wb = 1, rd = RA_IDX.
  - ret (0x14): alu = 0x0D, ubranch = 1, ret = 1.
  - out_is_imm = in_i for every opcode.
- Illegal opcode: all flags 0, alu = 0x0D, out_illegal = 1. No latching of stale values.
- Source set:
  - rs1 for all ops except mov, not, nop, b, call, beq, bgt.
  - rs2 when in_i = 0.
  - rd when st.
  - RA_IDX when ret.
- in_ready = !flush && (!out_valid || out_ready) && !ld_stall && mdiv_cnt == 0.
- Load-use: on an output transfer of a ld, capture ld_pend = 1 and ld_rd = out_rd for exactly the following cycle. ld_stall = ld_pend && the in-instruction sources include ld_rd.
- Multi-cycle: on an output transfer of mul/div/mod, set mdiv_cnt = MULDIV_LAT−1. Decrement by 1 each cycle while nonzero. Counter width is clog2(MULDIV_LAT)+1.
- Flush, at the edge where it is sampled:
  - out_valid ← 0, ld_pend ← 0, mdiv_cnt ← 0.
  - No input is accepted in that cycle.
  - Flush has priority over a simultaneous transfer.
- Output register:
  - Loads on input transfer.
  - Otherwise out_valid ← 0 on output transfer, else holds.
  - Bundle is stable while out_valid && !out_ready.

## Timing
- Latency: instruction accepted at edge N appears on out_* after edge N.
- Throughput: 1 per cycle with no hazards.
- Reset value: every output except in_ready is 0. in_ready is 1 after reset if flush = 0. Internal state ld_pend = 0, mdiv_cnt = 0.
- Reset mid-stall clears all interlocks immediately (asynchronous).
- Load-use inserts exactly one bubble. A dependent instruction presented the cycle after the ld transfer is accepted one cycle later.
- mul/div/mod: the next instruction is accepted no earlier than MULDIV_LAT cycles after the mul transfer edge.
- Simultaneous output transfer and new input: bundle replaced, out_valid stays 1.

## Structure
- Shared package/include holds opcode constants (0x00–0x14), ALU code constants (ADD = 0, NOP_ALU = 0x0D), and the control-bundle field list.
- Sub-module ctrl_decode: purely combinational opcode → bundle and source-set decode.
- Top level holds the handshake, output register, ld_pend/ld_rd, and mdiv_cnt.

## Test plan
- Reset asserted mid-stream → all out_* 0, out_valid 0. Release with opcode 0x00, rs1 = 1 → next cycle alu = 0, wb = 1, out_valid = 1.
- Sweep opcodes 0x00–0x14 with I = 0/1, then 0x15–0x1F. Check each flag against the map; call gives out_rd = 15; 0x1A gives out_illegal = 1, all flags 0.
- ld r3, then add r4, r3, r5 back-to-back with out_ready = 1 → in_ready low exactly 1 cycle, add appears 2 cycles after ld. The same pair with add r4, r6, r5 → no bubble.
- mul with MULDIV_LAT = 4, then add → in_ready low 3 cycles. Repeat with MULDIV_LAT = 1 → no stall.
- out_ready held 0 for 5 cycles with a valid bundle → bundle stable, in_ready 0. Release → next instruction follows immediately.
- Flush coincident with in_valid and a pending ld_pend/mdiv_cnt → out_valid 0 next cycle, instruction not accepted, no residual stall the following cycle.
